exhaustive_vector_checker: RTL and testbench
============================================

# exhaustive_vector_checker

Parametrised self-checking stimulus engine for small combinational blocks. On a start pulse it drives every N_IN-bit input combination in ascending order to a device under test, waits a programmable settle time per vector, and samples the device's response. It then compresses the responses into a MISR signature, counts the vectors with a non-zero response, and flags pass/fail against an expected signature. It sits beside the combinational sample circuits as the synthesisable successor to hand-written exhaustive benches.

## Interface
- N_IN, 3: DUT input width; sweeps 2**N_IN vectors (1..8).
- N_OUT, 1: DUT response width; must be <= SIG_W.
- SETTLE, 1: extra cycles each vector is held before sampling (0..15).
- SIG_W, 16: signature width.
- POLY, 16'h1021: MISR feedback polynomial (SIG_W bits).

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin sweep; honoured only in IDLE.
- resp  in  N_OUT  DUT response.
- expected_sig  in  SIG_W  golden signature, sampled when the sweep completes.
- pattern  out  N_IN  vector driven to the DUT.
- busy  out  1  high in WAIT and SAMPLE.
- sample_valid  out  1  high in the cycle resp is captured.
- done  out  1  one-cycle completion pulse.
- pass  out  1  signature == expected_sig; held until the next accepted start.
- ones_count  out  N_IN+1  number of vectors with resp != 0.
- signature  out  SIG_W  MISR result.
- truth_table  out  2**N_IN  per-vector resp[0] map; see Configuration.

## Operation
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE + start=1: load pattern=0, settle_cnt=0, signature=0, ones_count=0, truth_table=0, pass=0. Go to WAIT, or to SAMPLE if SETTLE==0.
- WAIT: settle_cnt increments each cycle. At settle_cnt==SETTLE-1, go to SAMPLE.
- SAMPLE: sample_valid=1.
  - signature <= ({sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? POLY : 0)) ^ zero-extended resp.
  - ones_count increments if resp != 0.
  - If pattern == all-ones: go to DONE.
  - Otherwise: pattern+1, settle_cnt=0, go to WAIT (or SAMPLE if SETTLE==0).
- DONE: done=1 for one cycle. pass <= (signature == expected_sig). Return to IDLE.
- Results (signature, ones_count, truth_table, pass) hold in IDLE until the next accepted start.
- start while busy, or in DONE: ignored.
- pattern never wraps during a sweep. After DONE it holds all-ones until the next start.

## Timing
- Reset values: pattern=0, busy=0, sample_valid=0, done=0, pass=0, ones_count=0, signature=0, truth_table=0. State is IDLE.
- Each vector is held for SETTLE+1 cycles. resp is sampled on the last of those cycles.
- Latency: done rises 2**N_IN*(SETTLE+1)+1 cycles after the edge that accepts start.
- rst asserted mid-sweep: all outputs take reset values immediately. A fresh start is required afterwards.
- busy is decoded from the registered state; there is no combinational path from start to busy.

## Configuration
- TRUTH_TABLE_EN defined: in SAMPLE, truth_table[pattern] <= resp[0]. The full minterm map is valid from done onward.
- TRUTH_TABLE_EN undefined: no map storage is built. truth_table is tied to 0. The port list is unchanged.

## Test plan
- N_IN=3, SETTLE=1, DUT F=(A&B)|C with pattern={A,B,C}, start pulse -> pattern steps 0..7, each held 2 cycles; ones_count=5; truth_table=8'hEA (with TRUTH_TABLE_EN); done 17 cycles after accept.
- resp tied 1, N_OUT=1, SIG_W=16, POLY=16'h1021 -> signature=16'h00FF. With expected_sig=16'h00FF, pass=1. With expected_sig=16'h00FE, pass=0.
- resp tied 0 -> signature=0, ones_count=0, truth_table=0.
- SETTLE=0 -> sample_valid high for 8 consecutive cycles; done 9 cycles after accept.
- start re-pulsed during busy -> ignored, sweep unaffected. rst raised at pattern=4 -> all outputs zero next edge. A new start yields correct results.
- TRUTH_TABLE_EN undefined, same DUT as the first scenario -> truth_table=0; other results identical.

Source files
------------

// File: rtl/exhaustive_vector_checker.sv
// Exhaustive sweep engine: drives every N_IN-bit vector, MISR-compresses responses, checks signature.
// Optional per-vector resp[0] minterm map is built when TRUTH_TABLE_EN is defined.
module exhaustive_vector_checker #(
  parameter int                N_IN   = 3,
  parameter int                N_OUT  = 1,
  parameter int                SETTLE = 1,
  parameter int                SIG_W  = 16,
  parameter logic [SIG_W-1:0]  POLY   = 16'h1021
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_OUT-1:0]     resp,
  input  logic [SIG_W-1:0]     expected_sig,
  output logic [N_IN-1:0]      pattern,
  output logic                 busy,
  output logic                 sample_valid,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        ones_count,
  output logic [SIG_W-1:0]     signature,
  output logic [2**N_IN-1:0]   truth_table
);
  localparam int NV = 2**N_IN;

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;
  // With no settle time a vector is sampled on the cycle it is first driven.
  localparam state_t FIRST = (SETTLE == 0) ? SAMPLE : WAIT;

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [SIG_W-1:0] sig_next;

  assign sig_next     = {signature[SIG_W-2:0], 1'b0}
                      ^ (signature[SIG_W-1] ? POLY : '0)
                      ^ SIG_W'(resp);
  assign busy         = (state == WAIT) || (state == SAMPLE);
  assign sample_valid = (state == SAMPLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pattern    <= '0;
      settle_cnt <= '0;
      signature  <= '0;
      ones_count <= '0;
      pass       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          pattern    <= '0;
          settle_cnt <= '0;
          signature  <= '0;
          ones_count <= '0;
          pass       <= 1'b0;
          state      <= FIRST;
        end
        WAIT: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (int'(settle_cnt) == SETTLE - 1) state <= SAMPLE;
        end
        SAMPLE: begin
          signature <= sig_next;
          if (|resp) ones_count <= ones_count + (N_IN+1)'(1);
          if (&pattern) begin
            state <= DONE;
          end else begin
            pattern    <= pattern + N_IN'(1);
            settle_cnt <= '0;
            state      <= FIRST;
          end
        end
        DONE: begin
          done  <= 1'b1;
          pass  <= (signature == expected_sig);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TRUTH_TABLE_EN
  logic [NV-1:0] tt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        tt_q <= '0;
    else if (state == IDLE && start) tt_q <= '0;
    else if (state == SAMPLE)       tt_q[pattern] <= resp[0];
  end
  assign truth_table = tt_q;
`else
  assign truth_table = {NV{1'b0}};
`endif

endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// Randomized bench for exhaustive_vector_checker: SETTLE=1 and SETTLE=0 instances vs a table-driven model.
module tb_exhaustive_vector_checker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start1, start0;
  logic [15:0] exp1, exp0;
  logic [7:0]  tbl;
  logic [0:0]  r1, r0;
  logic [2:0]  p1, p0;
  logic        busy1, busy0, sv1, sv0, done1, done0, pass1, pass0;
  logic [3:0]  ones1, ones0;
  logic [15:0] sig1, sig0;
  logic [7:0]  tt1, tt0;

  // The DUT-under-test is an 8-entry lookup table indexed by the driven pattern.
  assign r1 = tbl[p1];
  assign r0 = tbl[p0];

  exhaustive_vector_checker #(.N_IN(3), .N_OUT(1), .SETTLE(1), .SIG_W(16), .POLY(16'h1021)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .resp(r1), .expected_sig(exp1),
    .pattern(p1), .busy(busy1), .sample_valid(sv1), .done(done1), .pass(pass1),
    .ones_count(ones1), .signature(sig1), .truth_table(tt1));

  exhaustive_vector_checker #(.N_IN(3), .N_OUT(1), .SETTLE(0), .SIG_W(16), .POLY(16'h1021)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .resp(r0), .expected_sig(exp0),
    .pattern(p0), .busy(busy0), .sample_valid(sv0), .done(done0), .pass(pass0),
    .ones_count(ones0), .signature(sig0), .truth_table(tt0));

  int sel;
  logic [2:0]  s_pat;
  logic        s_busy, s_sv, s_done, s_pass;
  logic [3:0]  s_ones;
  logic [15:0] s_sig;
  logic [7:0]  s_tt;
  assign s_pat  = sel ? p1    : p0;
  assign s_busy = sel ? busy1 : busy0;
  assign s_sv   = sel ? sv1   : sv0;
  assign s_done = sel ? done1 : done0;
  assign s_pass = sel ? pass1 : pass0;
  assign s_ones = sel ? ones1 : ones0;
  assign s_sig  = sel ? sig1  : sig0;
  assign s_tt   = sel ? tt1   : tt0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signature as polynomial division over all 8 vectors in order, popcount, minterm map.
  function automatic void model(input logic [7:0] t, output logic [15:0] s, output int ones,
                                output logic [7:0] tt);
    s = '0; ones = 0;
    for (int v = 0; v < 8; v++) begin
      s = (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, t[v]};
      ones += int'(t[v]);
    end
`ifdef TRUTH_TABLE_EN
    tt = t;
`else
    tt = 8'h00;
`endif
  endfunction

  task automatic drive_start(input logic v);
    if (sel != 0) start1 = v; else start0 = v;
  endtask

  task automatic set_exp(input logic [15:0] e);
    if (sel != 0) exp1 = e; else exp0 = e;
  endtask

  // Runs one sweep and checks latency, sample cadence, pattern order and results.
  task automatic sweep(input string tag, input logic [15:0] expsig, input bit repulse);
    logic [15:0] ms; int mo; logic [7:0] mt;
    int lat, svn, first, last, badpat;
    lat = -1; svn = 0; first = -1; last = -1; badpat = 0;
    model(tbl, ms, mo, mt);
    set_exp(expsig);
    @(negedge clk); drive_start(1'b1);
    @(posedge clk); #1;
    chk({tag, "_busy_acc"}, {31'd0, s_busy}, 1);
    chk({tag, "_pass_clr"}, {31'd0, s_pass}, 0);
    for (int n = 0; n < 300; n++) begin
      if (s_sv) begin
        if (int'(s_pat) != svn) badpat++;
        if (svn == 0) first = n;
        last = n;
        svn++;
      end
      if (s_done) begin lat = n; break; end
      @(negedge clk); drive_start(repulse && (n == 4 || n == 5));
      @(posedge clk); #1;
    end
    chk({tag, "_latency"}, lat, (sel != 0) ? 17 : 9);
    chk({tag, "_nsamples"}, svn, 8);
    chk({tag, "_pat_order"}, badpat, 0);
    if (sel == 0) chk({tag, "_sv_consec"}, last - first, 7);
    chk({tag, "_sig"}, {16'd0, s_sig}, {16'd0, ms});
    chk({tag, "_ones"}, {28'd0, s_ones}, mo);
    chk({tag, "_tt"}, {24'd0, s_tt}, {24'd0, mt});
    chk({tag, "_pass"}, {31'd0, s_pass}, {31'd0, (ms == expsig)});
    chk({tag, "_pat_hold"}, {29'd0, s_pat}, 7);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {31'd0, s_done}, 0);
    repeat (2) @(posedge clk); #1;
    chk({tag, "_sig_hold"}, {16'd0, s_sig}, {16'd0, ms});
    chk({tag, "_pass_hold"}, {31'd0, s_pass}, {31'd0, (ms == expsig)});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pat"},  {29'd0, s_pat}, 0);
    chk({tag, "_busy"}, {31'd0, s_busy}, 0);
    chk({tag, "_sv"},   {31'd0, s_sv}, 0);
    chk({tag, "_done"}, {31'd0, s_done}, 0);
    chk({tag, "_pass"}, {31'd0, s_pass}, 0);
    chk({tag, "_ones"}, {28'd0, s_ones}, 0);
    chk({tag, "_sig"},  {16'd0, s_sig}, 0);
    chk({tag, "_tt"},   {24'd0, s_tt}, 0);
  endtask

  initial begin
    logic [15:0] ms; int mo; logic [7:0] mt;
    int wait_n;
    rst = 1'b1; start1 = 0; start0 = 0; exp1 = '0; exp0 = '0; tbl = '0; sel = 1;
    repeat (2) @(posedge clk); #1;
    sel = 1; chk_zero("rst1");
    sel = 0; chk_zero("rst0");
    @(negedge clk); rst = 1'b0;

    // F = (A&B)|C with pattern {A,B,C}
    sel = 1; tbl = 8'hEA;
    model(tbl, ms, mo, mt);
    sweep("fabc", ms, 1'b0);
    chk("fabc_ones_const", {28'd0, ones1}, 5);
`ifdef TRUTH_TABLE_EN
    chk("fabc_tt_const", {24'd0, tt1}, 32'hEA);
`endif

    tbl = 8'hFF;
    sweep("ones_ok", 16'h00FF, 1'b0);
    chk("ones_sig_const", {16'd0, sig1}, 32'h00FF);
    chk("ones_pass_const", {31'd0, pass1}, 1);
    sweep("ones_bad", 16'h00FE, 1'b0);
    chk("ones_bad_pass_const", {31'd0, pass1}, 0);

    tbl = 8'h00;
    sweep("zeros", 16'h0000, 1'b0);

    sel = 0; tbl = 8'hEA;
    model(tbl, ms, mo, mt);
    sweep("s0_fabc", ms, 1'b0);

    sel = 1; tbl = 8'($urandom);
    model(tbl, ms, mo, mt);
    sweep("repulse", ms, 1'b1);

    // Mid-sweep reset when pattern reaches 4
    tbl = 8'($urandom);
    set_exp(16'h0000);
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    wait_n = 0;
    while (p1 != 3'd4 && wait_n < 50) begin @(posedge clk); #1; wait_n++; end
    chk("rst_reach_p4", {29'd0, p1}, 4);
    rst = 1'b1; #1;
    chk_zero("midrst");
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("midrst_idle_busy", {31'd0, busy1}, 0);
    model(tbl, ms, mo, mt);
    sweep("after_rst", ms, 1'b0);

    for (int k = 0; k < 4; k++) begin
      sel = k % 2;
      tbl = 8'($urandom);
      model(tbl, ms, mo, mt);
      sweep($sformatf("rnd%0d", k), ($urandom_range(0, 1) != 0) ? ms : (ms ^ 16'(1 << $urandom_range(0, 15))), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
